encrypt_mult_scheduler: RTL
===========================

// Module: encrypt_mult_scheduler
// PURPOSE
//  Sequences the six polynomial products of Baby Kyber encryption (u = A^T*r, v = t^T*r)
//  through ONE shared polynomial multiplier instead of six parallel instances.
//  Adds the error terms e1 and e2 and the scaled message, reduces everything mod Q,
//  and presents u and v as the ciphertext. Sits between the keygen outputs and the ciphertext register.
// PARAMETERS
//  Q       17  modulus
//  QHALF   9   message scale, round(Q/2)
//  N       4   coefficients per polynomial
//  K       2   module rank
//  W       32  signed coefficient width
// PORTS
//  clk          in   1        single clock, rising edge
//  rst          in   1        synchronous, active-high reset
//  start        in   1        request; accepted only in IDLE or DONE
//  a_mat        in   K*K*N*W  A[k][i] poly, packed, index ((k*K+i)*N+j)
//  t_vec        in   K*N*W    public t[k]
//  r_vec        in   K*N*W    secret r[k], values in {-1,0,1}
//  e1_vec       in   K*N*W    error e1[i]
//  e2_poly      in   N*W      error e2
//  message      in   N        message bits, bit j -> coefficient j
//  mult_start   out  1        one-cycle pulse to the shared multiplier
//  mult_a       out  N*W      operand poly 1, held stable from pulse until mult_done
//  mult_b       out  N*W      operand poly 2, held the same way
//  mult_done    in   1        one-cycle result-valid from the multiplier
//  mult_result  in   N*W      signed product poly, unreduced
//  busy         out  1        high from accept until done
//  done         out  1        one-cycle pulse when u_out and v_out update
//  u_out        out  K*N*W    u[i][j] in [0,Q-1]
//  v_out        out  N*W      v[j] in [0,Q-1]
// BEHAVIOUR
//  Reset: every output 0; FSM goes to IDLE; accumulators and the job counter cleared.
//    A reset mid-job aborts the job; a late mult_done afterwards is ignored.
//  FSM: IDLE -(start)-> ISSUE -> WAIT -(mult_done)-> ACCUM
//    ACCUM -> ISSUE while job<5; ACCUM -> FINAL when job==5; FINAL -> DONE -> IDLE.
//    A start seen in DONE is accepted: DONE goes directly to ISSUE.
//  Accept: all inputs are latched on the cycle start is accepted; later input changes do not affect the job.
//    start while busy is ignored, with no queueing.
//  Job order (operands / destination):
//    0: A[0][0],r0 -> u0
//    1: A[1][0],r1 -> u0
//    2: A[0][1],r0 -> u1
//    3: A[1][1],r1 -> u1
//    4: t0,r0 -> v
//    5: t1,r1 -> v
//  ISSUE: mult_start=1 for exactly one cycle; operands driven from the latched copies.
//  WAIT: mult_done is sampled only in WAIT; any pulse in another state is ignored.
//  ACCUM: acc[j] = modq(acc[j] + mult_result[j]).
//    modq(x) = x%Q, plus Q if negative; result always in [0,Q-1].
//  FINAL:
//    u[i][j] = modq(acc_u[i][j] + e1[i][j])
//    v[j] = modq(acc_v[j] + e2[j] - (message[j] ? QHALF : 0))
//  DONE: u_out/v_out registered; done=1 for 1 cycle; outputs hold until the next DONE.
//  Latency, start accept to done: 6*(L+3)+2 cycles, where L = cycles from mult_start to mult_done.
//  Arithmetic: W-bit signed intermediates; accumulators 8-bit unsigned (fits 2Q).
// CONFIGURATION
//  Macro MULT_TIMEOUT_EN.
//  Defined: 8-bit watchdog counts cycles in WAIT.
//    At 255 the job aborts; FSM -> DONE with done=1, err=1 (extra output port err).
//    u_out/v_out are left unchanged. err clears on the next accepted start.
//  Undefined: no err port; WAIT waits indefinitely.
// STRUCTURE
//  kyber_pkg holds:
//    constants Q, QHALF, N, K
//    typedef coef_t (logic signed [W-1:0])
//    typedef poly_t (coef_t [N-1:0])
//    state_e enum
//    function modq
//  Sub-module modq_reduce: a combinational N-lane reducer, shared by the ACCUM and FINAL paths.
// TESTING
//  Bench multiplier model: schoolbook negacyclic product, latency L=3.
//  1. A=0, t=0, r=any, e1={0,1,1,0},{0,0,1,0}, e2={0,0,-1,-1}, message=4'b1011
//     -> u0={0,1,1,0}, u1={0,0,1,0}, v={8,8,16,7}; done after 38 cycles.
//  2. A[k][i]=t[k]={1,0,0,0}, r0={0,0,1,-1}, r1={-1,0,1,1}, e=0, msg=0
//     -> u0=u1=v={16,0,2,0}; exactly 6 mult_start pulses.
//  3. start pulsed during WAIT and a spurious mult_done during ISSUE
//     -> no extra job; result identical to scenario 2.
//  4. rst asserted in job 3 -> next cycle: busy=0, outputs 0;
//     a fresh start then completes correctly.
//  5. start held high continuously -> back-to-back jobs; DONE->ISSUE with no IDLE cycle.
//  6. MULT_TIMEOUT_EN defined, multiplier never answers
//     -> done and err at 255 cycles in WAIT; the next start clears err.

Source files
------------

// File: rtl/kyber_pkg.sv
// rtl/kyber_pkg.sv - Baby Kyber constants, coefficient types, scheduler states and mod-Q helper
package kyber_pkg;

    localparam int Q      = 17;
    localparam int QHALF  = 9;
    localparam int N      = 4;
    localparam int K      = 2;
    localparam int W      = 32;
    localparam int NLANES = (K + 1) * N;

    typedef logic signed [W-1:0] coef_t;
    typedef coef_t [N-1:0]       poly_t;
    typedef logic [7:0]          acc_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_ACCUM,
        S_FINAL,
        S_DONE
    } state_e;

    function automatic acc_t modq(input coef_t x);
        coef_t r;
        r = x % coef_t'(Q);
        if (r < 0) r = r + coef_t'(Q);
        return r[7:0];
    endfunction

    function automatic coef_t widen(input acc_t a);
        return coef_t'({{(W-8){1'b0}}, a});
    endfunction

endpackage

// File: rtl/modq_reduce.sv
// rtl/modq_reduce.sv - combinational multi-lane reduction of signed coefficients into [0,Q-1]
module modq_reduce
    import kyber_pkg::*;
#(
    parameter int LANES = N
) (
    input  logic [LANES*W-1:0] x_flat,
    output logic [LANES*8-1:0] y_flat
);

    always_comb begin
        y_flat = '0;
        for (int l = 0; l < LANES; l++) begin
            y_flat[l*8 +: 8] = modq($signed(x_flat[l*W +: W]));
        end
    end

endmodule

// File: rtl/encrypt_mult_scheduler.sv
// rtl/encrypt_mult_scheduler.sv - runs the six Baby Kyber encryption products through one shared multiplier
// Optional macro MULT_TIMEOUT_EN adds a WAIT watchdog and an err output.
module encrypt_mult_scheduler
    import kyber_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [K*K*N*W-1:0] a_mat,
    input  logic [K*N*W-1:0]   t_vec,
    input  logic [K*N*W-1:0]   r_vec,
    input  logic [K*N*W-1:0]   e1_vec,
    input  logic [N*W-1:0]     e2_poly,
    input  logic [N-1:0]       message,
    output logic               mult_start,
    output logic [N*W-1:0]     mult_a,
    output logic [N*W-1:0]     mult_b,
    input  logic               mult_done,
    input  logic [N*W-1:0]     mult_result,
    output logic               busy,
`ifdef MULT_TIMEOUT_EN
    output logic               err,
`endif
    output logic               done,
    output logic [K*N*W-1:0]   u_out,
    output logic [N*W-1:0]     v_out
);

    localparam int PW = N * W;

    state_e               state_q, state_d;
    logic [2:0]           job_q, job_d;
    logic [K*K*N*W-1:0]   a_q, a_d;
    logic [K*N*W-1:0]     t_q, t_d, r_q, r_d, e1_q, e1_d;
    logic [PW-1:0]        e2_q, e2_d;
    logic [N-1:0]         msg_q, msg_d;
    acc_t [NLANES-1:0]    acc_q, acc_d;
    logic [PW-1:0]        res_q, res_d;
    logic                 seen_q, seen_d;
    logic [K*N*W-1:0]     u_q, u_d;
    logic [PW-1:0]        v_q, v_d;
`ifdef MULT_TIMEOUT_EN
    logic [7:0]           wdog_q, wdog_d;
    logic                 err_q, err_d;
`endif

    logic [NLANES*W-1:0]  red_in;
    logic [NLANES*8-1:0]  red_out;
    coef_t                lane;
    int                   dest;

    // Lanes 0..K*N-1 hold u0,u1; the last N lanes hold v.
    always_comb begin
        red_in = '0;
        lane   = '0;
        dest   = job_q[2] ? K : int'(job_q[1]);
        for (int l = 0; l < K*N; l++) begin
            lane = widen(acc_q[l]);
            if (state_q == S_FINAL) lane = lane + $signed(e1_q[l*W +: W]);
            else if (l / N == dest) lane = lane + $signed(res_q[(l%N)*W +: W]);
            red_in[l*W +: W] = lane;
        end
        for (int j = 0; j < N; j++) begin
            lane = widen(acc_q[K*N+j]);
            if (state_q == S_FINAL) begin
                lane = lane + $signed(e2_q[j*W +: W]);
                if (msg_q[j]) lane = lane - coef_t'(QHALF);
            end else if (dest == K) begin
                lane = lane + $signed(res_q[j*W +: W]);
            end
            red_in[(K*N+j)*W +: W] = lane;
        end
    end

    modq_reduce #(.LANES(NLANES)) u_reduce (
        .x_flat (red_in),
        .y_flat (red_out)
    );

    // Operands come from the latched copies so they stay stable through WAIT.
    always_comb begin
        mult_b = job_q[0] ? r_q[PW +: PW] : r_q[0 +: PW];
        case (job_q)
            3'd0:    mult_a = a_q[0*PW +: PW];
            3'd1:    mult_a = a_q[2*PW +: PW];
            3'd2:    mult_a = a_q[1*PW +: PW];
            3'd3:    mult_a = a_q[3*PW +: PW];
            3'd4:    mult_a = t_q[0 +: PW];
            3'd5:    mult_a = t_q[PW +: PW];
            default: mult_a = '0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        job_d   = job_q;
        a_d     = a_q;
        t_d     = t_q;
        r_d     = r_q;
        e1_d    = e1_q;
        e2_d    = e2_q;
        msg_d   = msg_q;
        acc_d   = acc_q;
        res_d   = res_q;
        seen_d  = 1'b0;
        u_d     = u_q;
        v_d     = v_q;
`ifdef MULT_TIMEOUT_EN
        wdog_d  = wdog_q;
        err_d   = err_q;
`endif
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_ISSUE;
                    job_d   = 3'd0;
                    acc_d   = '0;
                    a_d     = a_mat;
                    t_d     = t_vec;
                    r_d     = r_vec;
                    e1_d    = e1_vec;
                    e2_d    = e2_poly;
                    msg_d   = message;
`ifdef MULT_TIMEOUT_EN
                    err_d   = 1'b0;
`endif
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ISSUE: begin
                state_d = S_WAIT;
`ifdef MULT_TIMEOUT_EN
                wdog_d  = 8'd0;
`endif
            end
            S_WAIT: begin
                if (seen_q) begin
                    state_d = S_ACCUM;
                end else if (mult_done) begin
                    seen_d = 1'b1;
                    res_d  = mult_result;
                end
`ifdef MULT_TIMEOUT_EN
                else if (wdog_q == 8'd254) begin
                    state_d = S_DONE;
                    err_d   = 1'b1;
                end else begin
                    wdog_d = wdog_q + 8'd1;
                end
`endif
            end
            S_ACCUM: begin
                for (int l = 0; l < NLANES; l++) acc_d[l] = red_out[l*8 +: 8];
                if (job_q == 3'd5) begin
                    state_d = S_FINAL;
                end else begin
                    job_d   = job_q + 3'd1;
                    state_d = S_ISSUE;
                end
            end
            S_FINAL: begin
                for (int l = 0; l < K*N; l++) u_d[l*W +: W] = widen(red_out[l*8 +: 8]);
                for (int j = 0; j < N; j++) v_d[j*W +: W] = widen(red_out[(K*N+j)*8 +: 8]);
                state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            job_q   <= '0;
            a_q     <= '0;
            t_q     <= '0;
            r_q     <= '0;
            e1_q    <= '0;
            e2_q    <= '0;
            msg_q   <= '0;
            acc_q   <= '0;
            res_q   <= '0;
            seen_q  <= 1'b0;
            u_q     <= '0;
            v_q     <= '0;
`ifdef MULT_TIMEOUT_EN
            wdog_q  <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            job_q   <= job_d;
            a_q     <= a_d;
            t_q     <= t_d;
            r_q     <= r_d;
            e1_q    <= e1_d;
            e2_q    <= e2_d;
            msg_q   <= msg_d;
            acc_q   <= acc_d;
            res_q   <= res_d;
            seen_q  <= seen_d;
            u_q     <= u_d;
            v_q     <= v_d;
`ifdef MULT_TIMEOUT_EN
            wdog_q  <= wdog_d;
            err_q   <= err_d;
`endif
        end
    end

    assign mult_start = (state_q == S_ISSUE);
    assign busy       = (state_q != S_IDLE) && (state_q != S_DONE);
    assign done       = (state_q == S_DONE);
    assign u_out      = u_q;
    assign v_out      = v_q;
`ifdef MULT_TIMEOUT_EN
    assign err        = err_q;
`endif

endmodule
